music_rom: RTL and testbench

- Synchronous read-only song table for the snowfall music path.
- Maps an 8-bit slot address, one slot per beat, to an 8-bit note code.
- The upstream sequencer steps `address`; the downstream tone generator converts `note` to a square-wave frequency.
- Contents are hard-coded: the Jingle Bells chorus, played twice with two different endings, followed by silence.

---
 rtl/music_rom_if.sv | 18 +
 rtl/music_rom.sv | 53 +++++
 tb/tb_music_rom.sv | 204 ++++++++++++++++++++
 3 files changed

// File: rtl/music_rom_if.sv
`default_nettype none
// ============================================================================
// Module      : music_rom_if
// Description : Read bus between the song sequencer and the song table.
//               address : 8-bit song slot index, driven by the sequencer
//               note    : 8-bit registered note code, driven by the table
//               master  : sequencer side (drives address, reads note)
//               slave   : table side (reads address, drives note)
// Revision    : 1.0 - initial release
// ============================================================================
interface music_rom_if;
  logic [7:0] address;
  logic [7:0] note;

  modport master (output address, input  note);
  modport slave  (input  address, output note);
endinterface : music_rom_if
`default_nettype wire

// File: rtl/music_rom.sv
`default_nettype none
// ============================================================================
// Module      : music_rom
// Description : Synchronous read-only song table for the snowfall music path.
//               One slot per beat; each slot holds a note code in semitones
//               from C4 (0 = rest). Holds the Jingle Bells chorus twice with
//               two endings, then silence up to slot 255.
// Ports       : clk    - rising-edge clock
//               rst_n  - asynchronous, active-low reset (note forced to 0)
//               bus    - music_rom_if.slave: address in, registered note out
// Revision    : 1.0 - initial release
// ============================================================================
module music_rom (
  input  wire          clk,
  input  wire          rst_n,
  music_rom_if.slave   bus
);

  // Song body, slots 0..63. Everything from slot 64 upward is silence.
  localparam logic [7:0] c_SONG [0:63] = '{
    8'd5, 8'd5, 8'd5, 8'd5,   8'd5, 8'd5, 8'd5, 8'd5,
    8'd5, 8'd8, 8'd1, 8'd3,   8'd5, 8'd5, 8'd5, 8'd5,
    8'd6, 8'd6, 8'd6, 8'd6,   8'd6, 8'd5, 8'd5, 8'd5,
    8'd5, 8'd3, 8'd3, 8'd5,   8'd3, 8'd3, 8'd8, 8'd8,
    8'd5, 8'd5, 8'd5, 8'd5,   8'd5, 8'd5, 8'd5, 8'd5,
    8'd5, 8'd8, 8'd1, 8'd3,   8'd5, 8'd5, 8'd5, 8'd5,
    8'd6, 8'd6, 8'd6, 8'd6,   8'd6, 8'd5, 8'd5, 8'd5,
    8'd8, 8'd8, 8'd6, 8'd3,   8'd1, 8'd1, 8'd1, 8'd1
  };

  logic [7:0] note_d;
  logic [7:0] note_q;

  // Any address with bits [7:6] set lies past the end of the song.
  always_comb begin
    note_d = 8'd0;
    if (bus.address[7:6] == 2'b00) begin
      note_d = c_SONG[bus.address[5:0]];
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      note_q <= 8'd0;
    end else begin
      note_q <= note_d;
    end
  end

  assign bus.note = note_q;

endmodule : music_rom
`default_nettype wire

// File: tb/tb_music_rom.sv
`default_nettype none
`timescale 1ns/100ps
// ============================================================================
// Module      : tb_music_rom
// Description : Directed self-checking bench for music_rom.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_music_rom;

  logic clk;
  logic rst_n;
  int   total;
  int   bad;

  music_rom_if bus ();

  music_rom dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  // 2 ns period, rising edges at odd nanoseconds.
  initial clk = 1'b0;
  always #1 clk = ~clk;

  // Reference song table written out from the slot listing.
  byte unsigned song [0:63] = '{
    5,5,5,5, 5,5,5,5, 5,8,1,3, 5,5,5,5,
    6,6,6,6, 6,5,5,5, 5,3,3,5, 3,3,8,8,
    5,5,5,5, 5,5,5,5, 5,8,1,3, 5,5,5,5,
    6,6,6,6, 6,5,5,5, 8,8,6,3, 1,1,1,1
  };

  function automatic logic [7:0] ref_note(input int a);
    if (a < 64) return 8'(song[a]);
    return 8'd0;
  endfunction

  // Drive an address, let one rising edge capture it, sample 0.5 ns later.
  task automatic read_addr(input logic [7:0] a, output logic [7:0] n);
    bus.address = a;
    @(posedge clk);
    #0.5;
    n = bus.note;
  endtask

  task automatic test_reset();
    logic [7:0] n;
    rst_n = 1'b0;
    bus.address = 8'd8;
    #0.3;
    total++;
    if (bus.note !== 8'd0) begin
      bad++; $display("FAIL reset_immediate: note=%0d expected=0", bus.note);
    end
    repeat (3) @(posedge clk);
    #0.5;
    total++;
    if (bus.note !== 8'd0) begin
      bad++; $display("FAIL reset_held_over_edges: note=%0d expected=0", bus.note);
    end
    @(negedge clk);
    rst_n = 1'b1;
    #0.3;
    total++;
    if (bus.note !== 8'd0) begin
      bad++; $display("FAIL reset_release_before_edge: note=%0d expected=0", bus.note);
    end
    @(posedge clk);
    #0.5;
    n = bus.note;
    total++;
    if (n !== 8'd5) begin
      bad++; $display("FAIL reset_first_read: note=%0d expected=5", n);
    end
  endtask

  // Address steps every 5 ns with a 0.3 ns phase so it never lands on an edge.
  task automatic test_full_sweep();
    realtime t0;
    @(negedge clk);
    #0.3;
    for (int a = 0; a < 200; a++) begin
      t0 = $realtime;
      bus.address = 8'(a);
      @(posedge clk);
      #0.5;
      total++;
      if (bus.note !== ref_note(a)) begin
        bad++;
        $display("FAIL sweep addr=%0d: note=%0d expected=%0d", a, bus.note, ref_note(a));
      end
      #(5.0 - ($realtime - t0));
    end
  endtask

  task automatic test_latency();
    logic [7:0] n;
    read_addr(8'd9, n);
    total++;
    if (n !== 8'd8) begin
      bad++; $display("FAIL latency_addr9: note=%0d expected=8", n);
    end
    bus.address = 8'd10;
    #0.2;
    total++;
    if (bus.note !== 8'd8) begin
      bad++; $display("FAIL latency_hold_after_change: note=%0d expected=8", bus.note);
    end
    @(negedge clk);
    #0.2;
    total++;
    if (bus.note !== 8'd8) begin
      bad++; $display("FAIL latency_hold_mid_cycle: note=%0d expected=8", bus.note);
    end
    @(posedge clk);
    #0.5;
    total++;
    if (bus.note !== 8'd1) begin
      bad++; $display("FAIL latency_next_edge: note=%0d expected=1", bus.note);
    end
  endtask

  task automatic test_song_boundary();
    logic [7:0] addrs [6] = '{8'd59, 8'd60, 8'd63, 8'd64, 8'd65, 8'd255};
    logic [7:0] exps  [6] = '{8'd3,  8'd1,  8'd1,  8'd0,  8'd0,  8'd0};
    logic [7:0] n;
    for (int i = 0; i < 6; i++) begin
      read_addr(addrs[i], n);
      total++;
      if (n !== exps[i]) begin
        bad++;
        $display("FAIL boundary addr=%0d: note=%0d expected=%0d", addrs[i], n, exps[i]);
      end
    end
  endtask

  task automatic test_endings();
    logic [7:0] addrs [4] = '{8'd26, 8'd58, 8'd30, 8'd62};
    logic [7:0] exps  [4] = '{8'd3,  8'd6,  8'd8,  8'd1};
    logic [7:0] n;
    for (int i = 0; i < 4; i++) begin
      read_addr(addrs[i], n);
      total++;
      if (n !== exps[i]) begin
        bad++;
        $display("FAIL ending addr=%0d: note=%0d expected=%0d", addrs[i], n, exps[i]);
      end
    end
  endtask

  task automatic test_async_reset_midstream();
    logic [7:0] n;
    read_addr(8'd16, n);
    total++;
    if (n !== 8'd6) begin
      bad++; $display("FAIL midreset_before: note=%0d expected=6", n);
    end
    // Now 0.5 ns after an edge; next rising edge is 1.5 ns away.
    rst_n = 1'b0;
    #0.1;
    total++;
    if (bus.note !== 8'd0) begin
      bad++; $display("FAIL midreset_immediate: note=%0d expected=0", bus.note);
    end
    #0.4;
    rst_n = 1'b1;
    #0.2;
    total++;
    if (bus.note !== 8'd0) begin
      bad++; $display("FAIL midreset_release_before_edge: note=%0d expected=0", bus.note);
    end
    @(posedge clk);
    #0.5;
    total++;
    if (bus.note !== 8'd6) begin
      bad++; $display("FAIL midreset_resume: note=%0d expected=6", bus.note);
    end
  endtask

  initial begin
    total = 0;
    bad   = 0;
    rst_n = 1'b0;
    bus.address = 8'd0;
    test_reset();
    test_full_sweep();
    test_latency();
    test_song_boundary();
    test_endings();
    test_async_reset_midstream();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #20000;
    $display("FAIL watchdog: run exceeded 20000 ns");
    $fatal(1, "watchdog");
  end

endmodule : tb_music_rom
`default_nettype wire
